// File: rtl/weight_load_ctrl_pkg.sv
// Shared definitions for the weight tile load controller: FSM state encoding
// and the default systolic-array dimension.
package weight_load_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wlc_state_e;

    localparam int WLC_SIZE_DEFAULT = 8;

endpackage

// File: rtl/wlc_addr_gen.sv
// Weight-memory address counter for one SIZE*SIZE tile: clears on tile entry,
// steps once per accepted weight, wraps after the last cell, and reports the column.
module wlc_addr_gen #(
    parameter int SIZE       = 8,
    parameter int ADDR_WIDTH = $clog2(SIZE*SIZE),
    parameter int COL_WIDTH  = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_incr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [COL_WIDTH-1:0]  o_col_idx,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE*SIZE-1);

    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_addr <= '0;
        end else if (i_incr) begin
            r_addr <= o_last ? '0 : r_addr + ADDR_WIDTH'(1);
        end
    end

    assign o_addr    = r_addr;
    assign o_last    = (r_addr == LAST_ADDR);
    // Weights are written column-major, SIZE cells per column.
    assign o_col_idx = COL_WIDTH'(r_addr / ADDR_WIDTH'(SIZE));

endmodule

// File: rtl/weight_load_ctrl.sv
// Streams one SIZE*SIZE signed weight tile into the weight preprocessing unit.
// Optional compensation-entry statistics are enabled by defining WLC_COMP_STAT_EN.
module weight_load_ctrl
    import weight_load_ctrl_pkg::*;
#(
    parameter int SIZE       = WLC_SIZE_DEFAULT,
    parameter int ADDR_WIDTH = $clog2(SIZE*SIZE),
    parameter int CNT_WIDTH  = $clog2(SIZE*3+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    w_valid,
    input  logic [7:0]              w_data,
    output logic                    w_ready,
    output logic [7:0]              wpu_weight,
    output logic [ADDR_WIDTH-1:0]   wpu_addr,
    output logic                    wpu_write,
    input  logic                    comp_valid,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(SIZE)-1:0] col_idx,
    output logic [CNT_WIDTH-1:0]    comp_count
);

    localparam int COL_WIDTH = $clog2(SIZE);

    wlc_state_e            r_state;
    wlc_state_e            w_state_next;
    logic                  r_drain_cnt;
    logic                  w_clear;
    logic                  w_hs;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            r_wpu_weight;
    logic [ADDR_WIDTH-1:0] r_wpu_addr;
    logic                  r_wpu_write;

    wlc_addr_gen #(
        .SIZE       (SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .COL_WIDTH  (COL_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_incr    (w_hs),
        .o_addr    (w_addr),
        .o_col_idx (col_idx),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= (r_state == DRAIN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_clear      = 1'b0;
        w_hs         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = LOAD;
                    w_clear      = 1'b1;
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                busy    = 1'b1;
                w_hs    = w_valid;
                if (w_valid && w_last) begin
                    w_state_next = DRAIN;
                end
            end
            // Two cycles let the unit's last compensation output land before done.
            DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wpu_write  <= 1'b0;
            r_wpu_weight <= '0;
            r_wpu_addr   <= '0;
        end else begin
            r_wpu_write <= w_hs;
            if (w_hs) begin
                r_wpu_weight <= w_data;
                r_wpu_addr   <= w_addr;
            end
        end
    end

    assign wpu_write  = r_wpu_write;
    assign wpu_weight = r_wpu_weight;
    assign wpu_addr   = r_wpu_addr;

`ifdef WLC_COMP_STAT_EN
    localparam logic [CNT_WIDTH-1:0] COMP_MAX = CNT_WIDTH'(SIZE*3);

    logic [CNT_WIDTH-1:0] r_comp_count;

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_comp_count <= '0;
        end else if (comp_valid && (busy || done) && (r_comp_count != COMP_MAX)) begin
            r_comp_count <= r_comp_count + CNT_WIDTH'(1);
        end
    end

    assign comp_count = r_comp_count;
`else
    logic w_unused_comp_valid;
    assign w_unused_comp_valid = comp_valid;
    assign comp_count          = '0;
`endif

endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning systolic-array dimension.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(SIZE*SIZE), meaning weight-memory address width.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(SIZE*3+1), meaning compensation-count width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1: one-cycle request to load one full SIZE*SIZE weight tile.
REQ-007 SHALL have port w_valid, input, 1: source weight valid.
REQ-008 SHALL have port w_data, input, 8: signed source weight.
REQ-009 SHALL have port w_ready, output, 1: controller accepts w_data.
REQ-010 SHALL have port wpu_weight, output, 8: weight driven to the weight preprocessing unit.
REQ-011 SHALL have port wpu_addr, output, ADDR_WIDTH: weight-memory address driven to that unit.
REQ-012 SHALL have port wpu_write, output, 1: memory-write strobe to that unit.
REQ-013 SHALL have port comp_valid, input, 1: compensation-output-valid returned by that unit.
REQ-014 SHALL have port busy, output, 1: tile load in progress.
REQ-015 SHALL have port done, output, 1: one-cycle tile-complete pulse.
REQ-016 SHALL have port col_idx, output, $clog2(SIZE): column currently being written.
REQ-017 SHALL have port comp_count, output, CNT_WIDTH: compensation entries produced for the tile.

Function
REQ-018 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE->LOAD on start; start in any other state SHALL be ignored.
REQ-020 w_ready SHALL equal (state==LOAD); a handshake is w_valid&&w_ready.
REQ-021 On a handshake at cycle N, wpu_weight=w_data, wpu_addr=address counter, and wpu_write=1 SHALL appear registered at cycle N+1; otherwise wpu_write=0 and wpu_weight/wpu_addr hold.
REQ-022 Address counter SHALL start at 0 on entry to LOAD and increment by 1 per handshake; col_idx = counter / SIZE.
REQ-023 w_valid low in LOAD SHALL stall: no write, counter holds, no timeout.
REQ-024 Handshake at address SIZE*SIZE-1 SHALL move LOAD->DRAIN and wrap the counter to 0.
REQ-025 DRAIN SHALL last exactly 2 cycles (covers unit's 1-cycle output latency), then DONE.
REQ-026 DONE SHALL last 1 cycle with done=1, then IDLE; busy=1 in LOAD and DRAIN only.
REQ-027 comp_count SHALL clear on IDLE->LOAD and increment by 1 each cycle comp_valid=1 while busy or done; saturates at SIZE*3.
REQ-028 comp_valid outside busy/DONE SHALL be ignored.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, counter 0, wpu_write=0, wpu_weight=0, wpu_addr=0, w_ready=0, busy=0, done=0, col_idx=0, comp_count=0.
REQ-030 rst mid-LOAD SHALL abandon the tile; no further wpu_write until a new start.

Configuration
REQ-031 Macro WLC_COMP_STAT_EN: when defined, comp_count behaves per REQ-027; when undefined, comp_count is tied to 0 and comp_valid is unused.

Structure
REQ-032 A shared package SHALL hold the state typedef (IDLE, LOAD, DRAIN, DONE) and the default SIZE constant.
REQ-033 Address/column counter SHALL be one sub-module, wlc_addr_gen (clear, increment, wrap, col_idx).

Verification
REQ-034 start, w_valid held 1, data 0..63 -> 64 writes at addr 0..63 each one cycle after accept; busy for 66 cycles; done one cycle later.
REQ-035 w_valid low for 5 cycles after addr 7 -> no wpu_write in gap, next write addr 8, col_idx=1.
REQ-036 comp_valid pulsed 10 times during tile (WLC_COMP_STAT_EN defined) -> comp_count=10 at done; undefined -> 0.
REQ-037 rst asserted after 20 accepts -> next cycle all outputs 0, state IDLE; new start loads from addr 0.
REQ-038 start pulsed while busy -> ignored, write count remains 64, single done pulse.
